// File: rtl/tophat_model_dumper.sv
// rtl/tophat_model_dumper.sv - decision-tree model read-back byte stream transmitter
module tophat_model_dumper #(
  parameter int NUM_INTERNAL    = 7,
  parameter int NUM_LEAVES      = 8,
  parameter int APPEND_CHECKSUM = 0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clear_i,
  input  logic                      start_i,
  input  logic                      model_loaded_i,
  input  logic [NUM_INTERNAL*3-1:0] node_feature_i,
  input  logic [NUM_INTERNAL*8-1:0] node_threshold_i,
  input  logic [NUM_INTERNAL*4-1:0] node_left_i,
  input  logic [NUM_INTERNAL*4-1:0] node_right_i,
  input  logic [NUM_LEAVES*8-1:0]   leaf_value_i,
  output logic                      byte_valid_o,
  output logic [7:0]                byte_o,
  input  logic                      byte_ready_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      err_o
);

  localparam int NODE_BYTES = NUM_INTERNAL * 4;
  localparam int N_MODEL    = NODE_BYTES + NUM_LEAVES;
  localparam int N_TOTAL    = N_MODEL + ((APPEND_CHECKSUM != 0) ? 1 : 0);
  // One spare code so the checksum position is always representable.
  localparam int IDX_W      = $clog2(N_TOTAL + 1);
  localparam int NODE_W     = (NUM_INTERNAL > 1) ? $clog2(NUM_INTERNAL) : 1;
  localparam int LEAF_W     = (NUM_LEAVES > 1) ? $clog2(NUM_LEAVES) : 1;

  localparam logic [IDX_W-1:0] NODE_END  = IDX_W'(NODE_BYTES);
  localparam logic [IDX_W-1:0] MODEL_END = IDX_W'(N_MODEL);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_TOTAL - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q;
  logic [7:0]        csum_q;
  logic              done_q, err_q;
  logic              done_d, err_d;
  logic              load, xfer;

  // Snapshot of the model taken at start; the stream only ever reads these.
  logic [2:0]        feat_q  [NUM_INTERNAL];
  logic [7:0]        thr_q   [NUM_INTERNAL];
  logic [3:0]        left_q  [NUM_INTERNAL];
  logic [3:0]        right_q [NUM_INTERNAL];
  logic [7:0]        leaf_q  [NUM_LEAVES];

  logic [NODE_W-1:0] node_sel;
  logic [LEAF_W-1:0] leaf_sel;
  logic [7:0]        cur_byte;

  // Encode the byte at the current index in loader order: node fields, leaves, checksum.
  always_comb begin
    node_sel = NODE_W'(idx_q >> 2);
    leaf_sel = LEAF_W'(idx_q - NODE_END);
    cur_byte = 8'h00;
    if (idx_q < NODE_END) begin
      case (idx_q[1:0])
        2'd0:    cur_byte = {5'b0, feat_q[node_sel]};
        2'd1:    cur_byte = thr_q[node_sel];
        2'd2:    cur_byte = {4'b0, left_q[node_sel]};
        default: cur_byte = {4'b0, right_q[node_sel]};
      endcase
    end else if (idx_q < MODEL_END) begin
      cur_byte = leaf_q[leaf_sel];
    end else begin
      cur_byte = csum_q;
    end
  end

  // State register; clear behaves exactly like reset.
  always_ff @(posedge clk) begin
    if (!rst_n || clear_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic plus the load/transfer strobes and status pulse requests.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    xfer    = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          if (model_loaded_i) begin
            state_d = SEND;
            load    = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      SEND: begin
        if (byte_ready_i) begin
          xfer = 1'b1;
          if (idx_q == LAST_IDX) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath: snapshot capture, index advance, running checksum, status pulses.
  always_ff @(posedge clk) begin
    if (!rst_n || clear_i) begin
      idx_q  <= '0;
      csum_q <= 8'h00;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      for (int i = 0; i < NUM_INTERNAL; i++) begin
        feat_q[i]  <= '0;
        thr_q[i]   <= '0;
        left_q[i]  <= '0;
        right_q[i] <= '0;
      end
      for (int j = 0; j < NUM_LEAVES; j++) begin
        leaf_q[j] <= '0;
      end
    end else begin
      done_q <= done_d;
      err_q  <= err_d;
      if (load) begin
        idx_q  <= '0;
        csum_q <= 8'h00;
        for (int i = 0; i < NUM_INTERNAL; i++) begin
          feat_q[i]  <= node_feature_i[i*3 +: 3];
          thr_q[i]   <= node_threshold_i[i*8 +: 8];
          left_q[i]  <= node_left_i[i*4 +: 4];
          right_q[i] <= node_right_i[i*4 +: 4];
        end
        for (int j = 0; j < NUM_LEAVES; j++) begin
          leaf_q[j] <= leaf_value_i[j*8 +: 8];
        end
      end else if (xfer) begin
        idx_q <= (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
        if (idx_q < MODEL_END) begin
          csum_q <= csum_q ^ cur_byte;
        end
      end
    end
  end

  assign byte_valid_o = (state_q == SEND);
  assign busy_o       = (state_q == SEND);
  assign byte_o       = byte_valid_o ? cur_byte : 8'h00;
  assign done_o       = done_q;
  assign err_o        = err_q;

endmodule
